rpn_sequencer: RTL
==================

Name: rpn_sequencer

Overview:
Controller that runs complete reverse-Polish expressions on STACK_BASED_ALU. It accepts a token stream (push operand / add / mul) over a valid/ready handshake and drives the ALU opcode and input_data one token per cycle. It mirrors stack depth to reject illegal tokens before they are issued, pops the final value and returns it with an error code. It sits between the command front-end and the ALU instance, and is the only master of the ALU ports.

Parameters:
DATA_WIDTH, 8, operand/result width; must match the ALU.
STACK_SIZE, 64, ALU stack capacity; bounds the depth mirror.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
tok_valid  in  1  token present
tok_ready  out  1  sequencer accepts token this cycle
tok_op  in  3  3'b110 push, 3'b100 add, 3'b101 mul; all other codes are illegal
tok_data  in  DATA_WIDTH  operand, push only
tok_last  in  1  final token of the expression
alu_opcode  out  3  to ALU opcode; 3'b000 = idle
alu_input_data  out  DATA_WIDTH  to ALU input_data
alu_output_data  in  DATA_WIDTH  from ALU output_data
alu_overflow  in  1  from ALU overflow
res_valid  out  1  result available
res_ready  in  1  result consumed
res_data  out  DATA_WIDTH  expression value; 0 on error
res_err  out  3  0 ok, 1 underflow, 2 stack full, 3 arithmetic overflow, 4 unbalanced
busy  out  1  state != IDLE
depth  out  $clog2(STACK_SIZE+1)  mirrored ALU stack depth

Behaviour:
- ALU contract: the ALU samples opcode/input_data on a rising edge. output_data and overflow are valid after that edge. The sequencer samples them on the next edge.
- Reset, asynchronous: state=IDLE, alu_opcode=000, alu_input_data=0, res_valid=0, res_data=0, res_err=0, depth=0, err_latch=0, arith_pend=0. rst_n must reset the ALU in the same cycle. A reset mid-expression discards the expression and no result is produced.
- All outputs are registered. alu_opcode is 000 on every cycle without an issue.
- States:
  - IDLE: tok_ready=1. The first handshake enters RUN and is processed exactly as in RUN.
  - RUN: tok_ready=1. On each handshake the token is checked against depth:
    - push with depth==STACK_SIZE -> err 2.
    - add/mul with depth<2 -> err 1.
    - illegal code -> err 1.
    - Otherwise the next-cycle alu_opcode is the token code and alu_input_data is tok_data. Push does depth+1; add/mul do depth-1.
    - A rejected token is never issued. err_latch keeps the first error only, and the state goes to FLUSH; if tok_last was set, it goes to END instead.
  - Arithmetic overflow check: arith_pend is set on add/mul issue. One cycle after issue, alu_overflow=1 sets err 3 if no earlier error. Later tokens may still be issued in that interval; subsequent tokens are then flushed.
  - FLUSH: tok_ready=1. Tokens are consumed and discarded until tok_last, then END.
  - END: tok_ready=0. Wait one cycle so arith_pend resolves. Then:
    - no error and depth==1 -> issue pop (111), go to CAPTURE.
    - no error and depth!=1 -> err 4.
    - any error with depth>0 -> DRAIN.
    - any error with depth==0 -> RESULT.
  - DRAIN: issue pop every cycle with depth-1 until depth==0, then RESULT. The ALU is left empty after every failed expression.
  - CAPTURE: res_data <= alu_output_data, depth=0, go to RESULT.
  - RESULT: res_valid=1 and outputs are held stable until res_ready. The handshake clears res_valid, err_latch and res_err, and returns to IDLE. tok_ready=0 while in RESULT.
- Simultaneous tok_valid and tok_last on the first token: the token is processed, then the state goes straight to END.
- Arithmetic wraps mod 2^DATA_WIDTH inside the ALU; the sequencer only reports overflow.
- Latency: the expression result appears 4 cycles after the tok_last handshake when there is no error and no backpressure.

Decomposition:
- Shared package rpn_pkg:
  - opcode constants OP_ADD=3'b100, OP_MUL=3'b101, OP_PUSH=3'b110, OP_POP=3'b111, OP_NOP=3'b000 (also used by STACK_BASED_ALU and its bench).
  - error-code constants ERR_OK/UNDERFLOW/FULL/OVF/UNBAL.
  - the FSM state enum.
- One sub-module, rpn_depth_tracker: depth counter with legality check (push/pop/binop inputs, full/underflow flags).
- Top-level rpn_sequencer holds the FSM, issue registers and result register. The bench instantiates it together with STACK_BASED_ALU.

Test Plan:
- Tokens push 05, push 03, add(last) -> one result, res_data=08, res_err=0, depth=0 afterwards, exactly one pop seen on alu_opcode.
- Tokens 02, 03, add, 04, mul(last), back-to-back valid -> tok_ready never drops in RUN, res_data=14h, err 0.
- Tokens 64h, 03h, mul(last) -> res_err=3, res_data=0, one drain pop, ALU depth 0.
- Single add(last) on an empty stack -> nothing issued to the ALU, res_err=1, no pops.
- Tokens 01, 02(last) -> res_err=4, two drain pops, then idle. Next, STACK_SIZE+1 pushes -> res_err=2 and STACK_SIZE drain pops.
- Hold res_ready=0 for 5 cycles -> res_valid and res_data stable, tok_ready=0. Assert rst_n=0 mid-expression -> all outputs at reset values next sample; a fresh expression 05, 03, add then gives 08.

Source files
------------

// File: rtl/rpn_pkg.sv
// Shared opcode, error-code and state definitions for the RPN sequencer and
// the stack ALU it drives.
package rpn_pkg;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;

    localparam logic [2:0] ERR_OK        = 3'd0;
    localparam logic [2:0] ERR_UNDERFLOW = 3'd1;
    localparam logic [2:0] ERR_FULL      = 3'd2;
    localparam logic [2:0] ERR_OVF       = 3'd3;
    localparam logic [2:0] ERR_UNBAL     = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_END,
        S_DRAIN,
        S_CAPTURE,
        S_RESULT
    } state_t;

endpackage

// File: rtl/rpn_depth_tracker.sv
// Mirror of the ALU stack depth, with the flags needed to judge a token's
// legality before it is issued.
module rpn_depth_tracker #(
    parameter int STACK_SIZE = 64,
    parameter int DEPTH_W    = $clog2(STACK_SIZE + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic               pop,
    input  logic               clr,
    output logic [DEPTH_W-1:0] depth,
    output logic               full,
    output logic               lt2,
    output logic               empty
);

    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] depth_d;

    assign depth = depth_q;
    assign full  = (depth_q == DEPTH_W'(STACK_SIZE));
    assign lt2   = (depth_q < DEPTH_W'(2));
    assign empty = (depth_q == '0);

    // pop covers both a real pop and a binary op (two in, one out)
    always_comb begin
        depth_d = depth_q;
        if (clr) begin
            depth_d = '0;
        end else if (push && !full) begin
            depth_d = depth_q + DEPTH_W'(1);
        end else if (pop && !empty) begin
            depth_d = depth_q - DEPTH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q <= '0;
        end else begin
            depth_q <= depth_d;
        end
    end

endmodule

// File: rtl/rpn_sequencer.sv
// Runs reverse-Polish token streams on the stack ALU, rejecting illegal tokens
// before issue and returning the final value with an error code.
module rpn_sequencer
    import rpn_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STACK_SIZE = 64
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               tok_valid,
    output logic                               tok_ready,
    input  logic [2:0]                         tok_op,
    input  logic [DATA_WIDTH-1:0]              tok_data,
    input  logic                               tok_last,
    output logic [2:0]                         alu_opcode,
    output logic [DATA_WIDTH-1:0]              alu_input_data,
    input  logic [DATA_WIDTH-1:0]              alu_output_data,
    input  logic                               alu_overflow,
    output logic                               res_valid,
    input  logic                               res_ready,
    output logic [DATA_WIDTH-1:0]              res_data,
    output logic [2:0]                         res_err,
    output logic                               busy,
    output logic [$clog2(STACK_SIZE+1)-1:0]    depth
);

    localparam int DEPTH_W = $clog2(STACK_SIZE + 1);

    state_t                  state_q, state_d;
    logic                    wait_q, wait_d;
    logic [1:0]              pend_q, pend_d;
    logic [2:0]              err_latch_q, err_d;
    logic [2:0]              alu_opcode_q, alu_opcode_d;
    logic [DATA_WIDTH-1:0]   alu_input_data_q, alu_input_data_d;
    logic                    res_valid_q, res_valid_d;
    logic [DATA_WIDTH-1:0]   res_data_q, res_data_d;
    logic [2:0]              res_err_q, res_err_d;
    logic                    tok_ready_q, tok_ready_d;
    logic                    busy_q, busy_d;

    logic                    trk_push, trk_pop, trk_clr;
    logic [DEPTH_W-1:0]      trk_depth;
    logic                    trk_full, trk_lt2, trk_empty;

    logic                    hs, is_push, is_bin, ovf_hit;
    logic [2:0]              err_cur, tok_err;

    rpn_depth_tracker #(
        .STACK_SIZE (STACK_SIZE),
        .DEPTH_W    (DEPTH_W)
    ) u_depth (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (trk_push),
        .pop   (trk_pop),
        .clr   (trk_clr),
        .depth (trk_depth),
        .full  (trk_full),
        .lt2   (trk_lt2),
        .empty (trk_empty)
    );

    assign tok_ready      = tok_ready_q;
    assign alu_opcode     = alu_opcode_q;
    assign alu_input_data = alu_input_data_q;
    assign res_valid      = res_valid_q;
    assign res_data       = res_data_q;
    assign res_err        = res_err_q;
    assign busy           = busy_q;
    assign depth          = trk_depth;

    assign hs      = tok_valid && tok_ready_q;
    assign is_push = (tok_op == OP_PUSH);
    assign is_bin  = (tok_op == OP_ADD) || (tok_op == OP_MUL);
    // pend_q[1] marks the edge where the ALU flag for an issued binop is readable
    assign ovf_hit = pend_q[1] && alu_overflow && (err_latch_q == ERR_OK);
    assign err_cur = ovf_hit ? ERR_OVF : err_latch_q;

    always_comb begin
        tok_err = ERR_OK;
        if (is_push) begin
            tok_err = trk_full ? ERR_FULL : ERR_OK;
        end else if (is_bin) begin
            tok_err = trk_lt2 ? ERR_UNDERFLOW : ERR_OK;
        end else begin
            tok_err = ERR_UNDERFLOW;
        end
    end

    always_comb begin
        state_d          = state_q;
        wait_d           = 1'b0;
        pend_d           = {pend_q[0], 1'b0};
        err_d            = err_cur;
        alu_opcode_d     = OP_NOP;
        alu_input_data_d = '0;
        res_valid_d      = res_valid_q;
        res_data_d       = res_data_q;
        res_err_d        = res_err_q;
        trk_push         = 1'b0;
        trk_pop          = 1'b0;
        trk_clr          = 1'b0;

        case (state_q)
            S_IDLE, S_RUN: begin
                if (hs) begin
                    if (err_cur != ERR_OK) begin
                        state_d = tok_last ? S_END : S_FLUSH;
                    end else if (tok_err != ERR_OK) begin
                        err_d   = tok_err;
                        state_d = tok_last ? S_END : S_FLUSH;
                    end else begin
                        alu_opcode_d     = tok_op;
                        alu_input_data_d = tok_data;
                        trk_push         = is_push;
                        trk_pop          = is_bin;
                        pend_d[0]        = is_bin;
                        state_d          = tok_last ? S_END : S_RUN;
                    end
                end else if (err_cur != ERR_OK) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (hs && tok_last) begin
                    state_d = S_END;
                end
            end
            S_END: begin
                if (!wait_q) begin
                    wait_d = 1'b1;
                end else if (err_cur == ERR_OK && trk_depth == DEPTH_W'(1)) begin
                    alu_opcode_d = OP_POP;
                    trk_pop      = 1'b1;
                    state_d      = S_CAPTURE;
                end else begin
                    if (err_cur == ERR_OK) begin
                        err_d = ERR_UNBAL;
                    end
                    if (!trk_empty) begin
                        state_d = S_DRAIN;
                    end else begin
                        res_valid_d = 1'b1;
                        res_data_d  = '0;
                        res_err_d   = (err_cur == ERR_OK) ? ERR_UNBAL : err_cur;
                        state_d     = S_RESULT;
                    end
                end
            end
            S_DRAIN: begin
                if (!trk_empty) begin
                    alu_opcode_d = OP_POP;
                    trk_pop      = 1'b1;
                end else begin
                    res_valid_d = 1'b1;
                    res_data_d  = '0;
                    res_err_d   = err_latch_q;
                    state_d     = S_RESULT;
                end
            end
            S_CAPTURE: begin
                // the pop lands in the ALU one edge after issue; read it one edge later
                if (!wait_q) begin
                    wait_d = 1'b1;
                end else begin
                    res_data_d  = alu_output_data;
                    res_err_d   = ERR_OK;
                    res_valid_d = 1'b1;
                    trk_clr     = 1'b1;
                    state_d     = S_RESULT;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    res_err_d   = ERR_OK;
                    err_d       = ERR_OK;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        tok_ready_d = (state_d == S_IDLE) || (state_d == S_RUN) || (state_d == S_FLUSH);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            wait_q           <= 1'b0;
            pend_q           <= 2'b00;
            err_latch_q      <= ERR_OK;
            alu_opcode_q     <= OP_NOP;
            alu_input_data_q <= '0;
            res_valid_q      <= 1'b0;
            res_data_q       <= '0;
            res_err_q        <= ERR_OK;
            tok_ready_q      <= 1'b1;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            wait_q           <= wait_d;
            pend_q           <= pend_d;
            err_latch_q      <= err_d;
            alu_opcode_q     <= alu_opcode_d;
            alu_input_data_q <= alu_input_data_d;
            res_valid_q      <= res_valid_d;
            res_data_q       <= res_data_d;
            res_err_q        <= res_err_d;
            tok_ready_q      <= tok_ready_d;
            busy_q           <= busy_d;
        end
    end

endmodule
